// File: rtl/pingpong_packer_if.sv
// Handshake bundle between the pingpong buffer, the packer and the wide-word consumer.
// parity_out is present only when PACK_PARITY_EN is defined.
interface pingpong_packer_if #(
  parameter int DATA_WD  = 8,
  parameter int PACK_NUM = 4
);
  logic                          valid_in;
  logic [DATA_WD-1:0]            data_in;
  logic                          last_in;
  logic                          ready_in;
  logic                          valid_out;
  logic [DATA_WD*PACK_NUM-1:0]   data_out;
  logic [PACK_NUM-1:0]           keep_out;
  logic                          ready_out;
`ifdef PACK_PARITY_EN
  logic                          parity_out;

  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, keep_out, parity_out
  );
  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, keep_out, parity_out
  );
`else
  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, keep_out
  );
  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, keep_out
  );
`endif
endinterface

// File: rtl/pingpong_packer.sv
// Packs PACK_NUM narrow beats into one wide word (lane 0 in the LSBs); last_in flushes a partial word.
// Optional macro PACK_PARITY_EN adds a registered parity_out over the filled lanes.
module pingpong_packer #(
  parameter int DATA_WD  = 8,
  parameter int PACK_NUM = 4
) (
  input  logic               clk,
  input  logic               rst,
  pingpong_packer_if.slave   bus
);
  localparam int CNT_WD  = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam int WORD_WD = DATA_WD * PACK_NUM;
  localparam logic [CNT_WD-1:0] LAST_LANE = CNT_WD'(PACK_NUM - 1);
  localparam logic [CNT_WD-1:0] ONE_LANE  = CNT_WD'(1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t               state_r;
  logic [CNT_WD-1:0]    lane_cnt_r;
  logic                 valid_r;
  logic [WORD_WD-1:0]   data_r;
  logic [PACK_NUM-1:0]  keep_r;
  logic [WORD_WD-1:0]   data_nxt_s;
  logic [PACK_NUM-1:0]  keep_nxt_s;
  logic                 ready_in_s;
  logic                 fire_in_s;
  logic                 fire_out_s;

  // In HOLD a beat may only enter when the held word leaves in the same cycle
  assign ready_in_s = (state_r == ST_COLLECT) ? 1'b1 : bus.ready_out;
  assign fire_in_s  = bus.valid_in & ready_in_s;
  assign fire_out_s = valid_r & bus.ready_out;

  assign bus.ready_in  = ready_in_s;
  assign bus.valid_out = valid_r;
  assign bus.data_out  = data_r;
  assign bus.keep_out  = keep_r;

`ifdef PACK_PARITY_EN
  logic parity_r;

  function automatic logic masked_parity(input logic [WORD_WD-1:0]  d,
                                         input logic [PACK_NUM-1:0] k);
    logic p;
    p = 1'b0;
    for (int i = 0; i < PACK_NUM; i++) begin
      p = p ^ ((^d[i*DATA_WD +: DATA_WD]) & k[i]);
    end
    return p;
  endfunction

  assign bus.parity_out = parity_r;
`endif

  // Next word contents: fill the current lane, or restart at lane 0 when the held word leaves
  always_comb begin
    data_nxt_s = data_r;
    keep_nxt_s = keep_r;
    case (state_r)
      ST_COLLECT: begin
        if (fire_in_s) begin
          data_nxt_s[lane_cnt_r*DATA_WD +: DATA_WD] = bus.data_in;
          keep_nxt_s[lane_cnt_r]                   = 1'b1;
        end else begin
          data_nxt_s = data_r;
        end
      end
      ST_HOLD: begin
        if (fire_out_s) begin
          data_nxt_s = {WORD_WD{1'b0}};
          keep_nxt_s = {PACK_NUM{1'b0}};
          if (fire_in_s) begin
            data_nxt_s[DATA_WD-1:0] = bus.data_in;
            keep_nxt_s[0]           = 1'b1;
          end else begin
            keep_nxt_s[0] = 1'b0;
          end
        end else begin
          data_nxt_s = data_r;
        end
      end
      default: begin
        data_nxt_s = {WORD_WD{1'b0}};
        keep_nxt_s = {PACK_NUM{1'b0}};
      end
    endcase
  end

  // Packer FSM with registered word, keep mask, valid and parity
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_COLLECT;
      lane_cnt_r <= {CNT_WD{1'b0}};
      valid_r    <= 1'b0;
      data_r     <= {WORD_WD{1'b0}};
      keep_r     <= {PACK_NUM{1'b0}};
`ifdef PACK_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      data_r <= data_nxt_s;
      keep_r <= keep_nxt_s;
`ifdef PACK_PARITY_EN
      parity_r <= masked_parity(data_nxt_s, keep_nxt_s);
`endif
      case (state_r)
        ST_COLLECT: begin
          if (fire_in_s) begin
            if ((lane_cnt_r == LAST_LANE) || bus.last_in) begin
              state_r    <= ST_HOLD;
              valid_r    <= 1'b1;
              lane_cnt_r <= {CNT_WD{1'b0}};
            end else begin
              lane_cnt_r <= lane_cnt_r + ONE_LANE;
            end
          end
        end
        ST_HOLD: begin
          if (fire_out_s) begin
            if (fire_in_s && bus.last_in) begin
              // single-beat word replaces the departing one; stay presenting
              lane_cnt_r <= {CNT_WD{1'b0}};
            end else if (fire_in_s) begin
              state_r    <= ST_COLLECT;
              valid_r    <= 1'b0;
              lane_cnt_r <= ONE_LANE;
            end else begin
              state_r    <= ST_COLLECT;
              valid_r    <= 1'b0;
              lane_cnt_r <= {CNT_WD{1'b0}};
            end
          end
        end
        default: begin
          state_r    <= ST_COLLECT;
          valid_r    <= 1'b0;
          lane_cnt_r <= {CNT_WD{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pingpong_packer.sv
// Directed, table-driven bench for pingpong_packer (DATA_WD=8, PACK_NUM=4).
module tb_pingpong_packer;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        r;
    logic        e_rin;
    logic        e_vout;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
  } vec_t;

  vec_t tbl[$];

  pingpong_packer_if #(.DATA_WD(8), .PACK_NUM(4)) bus ();

  pingpong_packer #(.DATA_WD(8), .PACK_NUM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                     input logic erin, input logic evout, input logic [31:0] edata,
                     input logic [3:0] ekeep);
    vec_t t;
    t = '{v, d, l, r, erin, evout, edata, ekeep};
    tbl.push_back(t);
  endtask

  // Outputs are checked 2 time units after the previous edge, then the edge consumes the inputs.
  task automatic check(input string name, input logic erin, input logic evout,
                       input logic [31:0] edata, input logic [3:0] ekeep);
    logic ok;
    ok = (bus.ready_in === erin) && (bus.valid_out === evout) &&
         (bus.data_out === edata) && (bus.keep_out === ekeep);
`ifdef PACK_PARITY_EN
    ok = ok && (bus.parity_out === (^edata));
`endif
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got rin=%b vout=%b data=%h keep=%b, want rin=%b vout=%b data=%h keep=%b",
               name, bus.ready_in, bus.valid_out, bus.data_out, bus.keep_out,
               erin, evout, edata, ekeep);
    end
  endtask

  task automatic step(input string name, input logic v, input logic [7:0] d, input logic l,
                      input logic r, input logic erin, input logic evout,
                      input logic [31:0] edata, input logic [3:0] ekeep);
    bus.valid_in  = v;
    bus.data_in   = v ? d : 8'h00;
    bus.last_in   = l;
    bus.ready_out = r;
    #1;
    check(name, erin, evout, edata, ekeep);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = 8'h00;
    bus.last_in   = 1'b0;
    bus.ready_out = 1'b0;

    // full word 11..44
    add(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    add(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0011, 4'b0001);
    add(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2211, 4'b0011);
    add(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0033_2211, 4'b0111);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4433_2211, 4'b1111);
    // partial word AA, BB(last)
    add(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    add(1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_00AA, 4'b0001);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_BBAA, 4'b0011);
    // continuous 12-beat stream, no bubbles
    add(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    add(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 4'b0001);
    add(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0201, 4'b0011);
    add(1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0003_0201, 4'b0111);
    add(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0403_0201, 4'b1111);
    add(1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 4'b0001);
    add(1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0605, 4'b0011);
    add(1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0007_0605, 4'b0111);
    add(1'b1, 8'h09, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0807_0605, 4'b1111);
    add(1'b1, 8'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0009, 4'b0001);
    add(1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0A09, 4'b0011);
    add(1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000B_0A09, 4'b0111);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0C0B_0A09, 4'b1111);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    // last_in on the 4th beat yields one full word
    add(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    add(1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00A1, 4'b0001);
    add(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_A2A1, 4'b0011);
    add(1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00A3_A2A1, 4'b0111);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA4A3_A2A1, 4'b1111);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    // single-beat last words back to back: HOLD stays HOLD
    add(1'b1, 8'hC1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    add(1'b1, 8'hC2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00C1, 4'b0001);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00C2, 4'b0001);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_state", 1'b1, 1'b0, 32'h0, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r,
           tbl[i].e_rin, tbl[i].e_vout, tbl[i].e_data, tbl[i].e_keep);
    end

    // backpressure: word held 5 cycles, released with a beat landing in lane 0
    step("bp_b0", 1'b1, 8'h51, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    step("bp_b1", 1'b1, 8'h52, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0051, 4'b0001);
    step("bp_b2", 1'b1, 8'h53, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_5251, 4'b0011);
    step("bp_b3", 1'b1, 8'h54, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0053_5251, 4'b0111);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("bp_hold%0d", i), 1'b1, 8'h61, 1'b0, 1'b0,
           1'b0, 1'b1, 32'h5453_5251, 4'b1111);
    end
    step("bp_release", 1'b1, 8'h61, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5453_5251, 4'b1111);
    step("bp_lane0",   1'b1, 8'h62, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0061, 4'b0001);
    step("bp_lane1",   1'b1, 8'h63, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_6261, 4'b0011);
    step("bp_lane2",   1'b1, 8'h64, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0063_6261, 4'b0111);
    step("bp_word2",   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h6463_6261, 4'b1111);
    step("bp_idle",    1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);

    // reset in the middle of a word discards it
    step("rs_b0", 1'b1, 8'h71, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    step("rs_b1", 1'b1, 8'h72, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0071, 4'b0001);
    rst = 1'b1;
    step("rs_pre", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_7271, 4'b0011);
    rst = 1'b0;
    step("rs_after", 1'b1, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    step("rs_n1",    1'b1, 8'h82, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0081, 4'b0001);
    step("rs_n2",    1'b1, 8'h83, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_8281, 4'b0011);
    step("rs_n3",    1'b1, 8'h84, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0083_8281, 4'b0111);
    step("rs_word",  1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8483_8281, 4'b1111);
    step("rs_idle",  1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);

    // parity words: 01,02(last) -> even; 01(last) -> odd
    step("par_b0",   1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    step("par_b1",   1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0001, 4'b0001);
    step("par_w0",   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0201, 4'b0011);
    step("par_b2",   1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);
    step("par_w1",   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0001, 4'b0001);
    step("par_idle", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
